// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX hazard inputs and front-end controls.
// The pipeline drives through master; the controller uses slave.
interface hazard_ctrl_if;
   logic [4:0]  ID_Rs_i;
   logic [4:0]  ID_Rt_i;
   logic        ID_UsesRt_i;
   logic        ID_HiLo_i;
   logic        IDEX_MemRead_i;
   logic [4:0]  IDEX_Rt_i;
   logic        EX_BranchTaken_i;
   logic        EX_MulDiv_i;
   logic        EX_IsDiv_i;
   logic        PC_write_o;
   logic        IFID_write_o;
   logic        IFID_flush_o;
   logic        IDEX_bubble_o;
   logic        HiLo_we_o;
   logic        MulDiv_busy_o;
   logic [15:0] Stall_cnt_o;

   modport master (
      output ID_Rs_i, ID_Rt_i, ID_UsesRt_i, ID_HiLo_i, IDEX_MemRead_i, IDEX_Rt_i,
             EX_BranchTaken_i, EX_MulDiv_i, EX_IsDiv_i,
      input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, HiLo_we_o,
             MulDiv_busy_o, Stall_cnt_o
   );

   modport slave (
      input  ID_Rs_i, ID_Rt_i, ID_UsesRt_i, ID_HiLo_i, IDEX_MemRead_i, IDEX_Rt_i,
             EX_BranchTaken_i, EX_MulDiv_i, EX_IsDiv_i,
      output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, HiLo_we_o,
             MulDiv_busy_o, Stall_cnt_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage CPU: load-use and HI/LO stalls, taken-branch flush,
// and tracking of the background multiply/divide unit.
module hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   hazard_ctrl_if.slave  hzBus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      stateQ, stateD, stateEff;
   logic [5:0]  cntQ, cntD;
   logic [15:0] stallCntQ;
   logic        loadUse, hiloStall, stall, mdBusy, hiLoWe;

   // Reset forces the outputs to look IDLE in the reset cycle itself, even mid-BUSY.
   assign stateEff = rst_i ? IDLE : stateQ;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      mdBusy = 1'b0;
      hiLoWe = 1'b0;
      unique case (stateEff)
         IDLE: begin
            if (hzBus.EX_MulDiv_i) begin
               stateD = BUSY;
               cntD   = hzBus.EX_IsDiv_i ? 6'(DIV_CYCLES - 1) : 6'(MUL_CYCLES - 1);
               mdBusy = 1'b1;
            end
         end
         BUSY: begin
            if (cntQ == 6'd0) begin
               hiLoWe = 1'b1;
               stateD = IDLE;
            end else begin
               mdBusy = 1'b1;
               cntD   = cntQ - 6'd1;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   assign loadUse = hzBus.IDEX_MemRead_i && (hzBus.IDEX_Rt_i != 5'd0) &&
                    ((hzBus.IDEX_Rt_i == hzBus.ID_Rs_i) ||
                     (hzBus.ID_UsesRt_i && (hzBus.IDEX_Rt_i == hzBus.ID_Rt_i)));
   assign hiloStall = hzBus.ID_HiLo_i && mdBusy;
   assign stall     = loadUse || hiloStall;

   // A taken branch wins over a stall: the stalled ID instruction is wrong-path.
   always_comb begin
      hzBus.PC_write_o    = 1'b1;
      hzBus.IFID_write_o  = 1'b1;
      hzBus.IFID_flush_o  = 1'b0;
      hzBus.IDEX_bubble_o = 1'b0;
      if (hzBus.EX_BranchTaken_i) begin
         hzBus.IFID_flush_o  = 1'b1;
         hzBus.IDEX_bubble_o = 1'b1;
      end else if (stall) begin
         hzBus.PC_write_o    = 1'b0;
         hzBus.IFID_write_o  = 1'b0;
         hzBus.IDEX_bubble_o = 1'b1;
      end
   end

   assign hzBus.HiLo_we_o     = hiLoWe;
   assign hzBus.MulDiv_busy_o = mdBusy;
   assign hzBus.Stall_cnt_o   = stallCntQ;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stateQ    <= IDLE;
         cntQ      <= 6'd0;
         stallCntQ <= 16'd0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (stall && !hzBus.EX_BranchTaken_i && (stallCntQ != 16'hFFFF))
            stallCntQ <= stallCntQ + 16'd1;
      end
   end

endmodule
